// File: rtl/diffamp_spike_pkg.sv
// Shared types and constants for the diffamp spike encoder.
// State encoding, the 8-bit debounce/refractory counter type and the
// legal parameter ranges of the encoder.
package diffamp_spike_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    REFRACT  = 2'd3
  } state_e;

  // Debounce and refractory counters are always 8 bits wide.
  typedef logic [7:0] dbcnt_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MIN    = 1;
  localparam int DEBOUNCE_MAX    = 255;
  localparam int REFRAC_MIN      = 0;
  localparam int REFRAC_MAX      = 255;

endpackage

// File: rtl/diffamp_spike_encoder_sync.sv
// Flop chain bringing the asynchronous slicer decision into the clk domain.
// All stages clear to 0 on reset.
module spike_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw decision through the chain, oldest sample at the top bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/diffamp_spike_encoder.sv
// Amplifier-to-neuron interface: synchronizes the slicer decision, debounces
// a low level then a high level, emits a one-cycle spike, holds off for a
// refractory period and keeps a saturating spike count.
// Optional feature macro: DIFFAMP_SPIKE_ISI_EN adds isi/isi_valid outputs
// reporting the cycles between consecutive spikes.
module diffamp_spike_encoder
  import diffamp_spike_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int REFRAC      = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmp,
  input  logic             cnt_clr,
  output logic             spike,
  output logic [CNT_W-1:0] spike_cnt,
  output logic             ovf,
  output logic             busy
`ifdef DIFFAMP_SPIKE_ISI_EN
  ,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid
`endif
);

  localparam dbcnt_t DEB_LAST = dbcnt_t'(DEBOUNCE - 1);
  localparam dbcnt_t REF_LOAD = dbcnt_t'(REFRAC);

  logic             w_cmp_s;
  state_e           r_state, w_state_next;
  dbcnt_t           r_lo, w_lo_next;
  dbcnt_t           r_hi, w_hi_next;
  dbcnt_t           r_ref, w_ref_next;
  logic             w_fire;
  logic [CNT_W-1:0] w_cnt_base, w_cnt_next;
  logic             w_ovf_base, w_ovf_next;

  spike_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (cmp),
    .o_q (w_cmp_s)
  );

  // Next state and counters; w_fire marks the edge that enters FIRE.
  always_comb begin
    w_state_next = r_state;
    w_lo_next    = r_lo;
    w_hi_next    = r_hi;
    w_ref_next   = r_ref;
    w_fire       = 1'b0;
    if (!en) begin
      w_state_next = WAIT_LOW;
      w_lo_next    = '0;
      w_hi_next    = '0;
      w_ref_next   = '0;
    end else begin
      case (r_state)
        WAIT_LOW: begin
          if (w_cmp_s) begin
            w_lo_next = '0;
          end else if (r_lo == DEB_LAST) begin
            w_state_next = ARMED;
            w_lo_next    = '0;
            w_hi_next    = '0;
          end else begin
            w_lo_next = r_lo + 8'd1;
          end
        end
        ARMED: begin
          if (!w_cmp_s) begin
            w_hi_next = '0;
          end else if (r_hi == DEB_LAST) begin
            w_state_next = FIRE;
            w_hi_next    = '0;
            w_fire       = 1'b1;
          end else begin
            w_hi_next = r_hi + 8'd1;
          end
        end
        FIRE: begin
          w_lo_next = '0;
          if (REFRAC == 0) begin
            w_state_next = WAIT_LOW;
          end else begin
            w_state_next = REFRACT;
            w_ref_next   = REF_LOAD;
          end
        end
        default: begin
          // REFRACT: the comparator is ignored until the hold-off expires.
          w_lo_next = '0;
          if (r_ref <= 8'd1) begin
            w_state_next = WAIT_LOW;
            w_ref_next   = '0;
          end else begin
            w_ref_next = r_ref - 8'd1;
          end
        end
      endcase
    end
  end

  // Spike count: an optional clear is applied first, then the new spike.
  always_comb begin
    w_cnt_base = cnt_clr ? '0 : spike_cnt;
    w_ovf_base = cnt_clr ? 1'b0 : ovf;
    w_cnt_next = w_cnt_base;
    w_ovf_next = w_ovf_base;
    if (w_fire) begin
      if (&w_cnt_base) begin
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = w_cnt_base + CNT_W'(1);
      end
    end
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_LOW;
      r_lo      <= '0;
      r_hi      <= '0;
      r_ref     <= '0;
      spike     <= 1'b0;
      busy      <= 1'b0;
      spike_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lo      <= w_lo_next;
      r_hi      <= w_hi_next;
      r_ref     <= w_ref_next;
      spike     <= w_fire;
      busy      <= (w_state_next != WAIT_LOW);
      spike_cnt <= w_cnt_next;
      ovf       <= w_ovf_next;
    end
  end

`ifdef DIFFAMP_SPIKE_ISI_EN
  logic [CNT_W-1:0] r_isi_cnt;
  logic [CNT_W-1:0] w_isi_inc;
  logic             r_isi_have;

  assign w_isi_inc = (&r_isi_cnt) ? r_isi_cnt : r_isi_cnt + CNT_W'(1);

  // Inter-spike interval: free-running saturating counter restarted at each
  // FIRE entry; reported only once a previous spike is known.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isi_cnt  <= '0;
      r_isi_have <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      r_isi_cnt <= w_fire ? '0 : w_isi_inc;
      if (!en) begin
        r_isi_have <= 1'b0;
      end else if (w_fire) begin
        if (r_isi_have && !cnt_clr) begin
          isi       <= w_isi_inc;
          isi_valid <= 1'b1;
        end
        r_isi_have <= 1'b1;
      end else if (cnt_clr) begin
        r_isi_have <= 1'b0;
      end
    end
  end
`endif

endmodule
